// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - push-button conditioner: synchronizer, debouncer, press/release strobes, auto-repeat
// All state is on CLK; step_pulse is the counter increment enable for the display path.
module button_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 12000,
  parameter int ACTIVE_LOW      = 1,
  parameter int REPEAT_DELAY    = 6000000,
  parameter int REPEAT_RATE     = 1200000
) (
  input  logic CLK,
  input  logic RST,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse,
  output logic step_pulse
);

  localparam logic REL_LVL = (ACTIVE_LOW != 0);
  localparam int   DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int   RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int   RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

  localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] RD_LAST = RPT_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [RPT_W-1:0] RR_LAST = RPT_W'((REPEAT_RATE > 0) ? REPEAT_RATE - 1 : 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
  logic                   level_q, level_d;
  logic                   press_q, press_d;
  logic                   release_q, release_d;
  logic                   repeat_q, repeat_d;
  state_t                 state_q, state_d;
  logic [RPT_W-1:0]       rpt_cnt_q, rpt_cnt_d;
  logic                   sync_n;

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], btn_in};
    sync_n    = sync_q[SYNC_STAGES-1] ^ REL_LVL;
    level_d   = level_q;
    db_cnt_d  = '0;
    press_d   = 1'b0;
    release_d = 1'b0;
    // Any agreement with the current level restarts the stability count.
    if (sync_n != level_q) begin
      if (db_cnt_q == DB_LAST) begin
        level_d   = ~level_q;
        press_d   = ~level_q;
        release_d = level_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rpt_cnt_d = rpt_cnt_q;
    repeat_d  = 1'b0;
    if (release_d || (REPEAT_DELAY == 0)) begin
      state_d   = IDLE;
      rpt_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          rpt_cnt_d = '0;
          if (press_d) state_d = DELAY;
        end
        DELAY: begin
          if (rpt_cnt_q == RD_LAST) begin
            repeat_d  = 1'b1;
            state_d   = REPEAT;
            rpt_cnt_d = '0;
          end else begin
            rpt_cnt_d = rpt_cnt_q + 1'b1;
          end
        end
        REPEAT: begin
          if (rpt_cnt_q == RR_LAST) begin
            repeat_d  = 1'b1;
            rpt_cnt_d = '0;
          end else begin
            rpt_cnt_d = rpt_cnt_q + 1'b1;
          end
        end
        default: begin
          state_d   = IDLE;
          rpt_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q    <= {SYNC_STAGES{REL_LVL}};
      db_cnt_q  <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
      state_q   <= IDLE;
      rpt_cnt_q <= '0;
    end else begin
      sync_q    <= sync_d;
      db_cnt_q  <= db_cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
      state_q   <= state_d;
      rpt_cnt_q <= rpt_cnt_d;
    end
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign repeat_pulse  = repeat_q;
  assign step_pulse    = press_q | repeat_q;

endmodule

// File: doc/button_debounce.md
Name: button_debounce

Overview:
Conditions a raw mechanical push-button input into clean, single-clock control strobes for the display counter logic. Chain: 2-FF-style synchronizer, then stability-counter debouncer, then press/release edge detection, then an optional hold-to-auto-repeat state machine. Sits between the board button pin and the counter that feeds the seven-segment display path. All counter logic runs on the system clock, never on the button edge.

Parameters:
SYNC_STAGES, 2, synchronizer flop count (>=2)
DEBOUNCE_CYCLES, 12000, consecutive clocks the synchronized input must differ from btn_level before btn_level flips (>=1; 1 ms at 12 MHz)
ACTIVE_LOW, 1, 1 = pin reads 0 when pressed
REPEAT_DELAY, 6000000, held clocks after press before first repeat pulse; 0 disables auto-repeat
REPEAT_RATE, 1200000, clocks between subsequent repeat pulses (>=1)

Ports:
CLK  input  1  system clock
RST  input  1  synchronous reset, active-high
btn_in  input  1  raw asynchronous button pin
btn_level  output  1  debounced level, 1 = pressed (polarity normalized)
press_pulse  output  1  one-clock strobe on debounced press
release_pulse  output  1  one-clock strobe on debounced release
repeat_pulse  output  1  one-clock strobe per auto-repeat tick while held
step_pulse  output  1  press_pulse OR repeat_pulse (counter increment enable)

Behaviour:
- Reset (RST high at CLK edge): synchronizer flops load the "released" pin level (1 if ACTIVE_LOW); debounce counter = 0; btn_level = 0; all pulses = 0; FSM = IDLE; repeat counter = 0. RST dominates all other activity.
- Polarity is normalized after synchronization: sync_n = sync XOR ACTIVE_LOW. Internal logic is active-high.
- Debounce: when sync_n != btn_level, counter increments each clock. When sync_n == btn_level, counter clears to 0. When the counter reaches DEBOUNCE_CYCLES-1 and sync_n still differs, btn_level flips on that edge and the counter clears. Any mismatch gap restarts the count; glitches shorter than DEBOUNCE_CYCLES are invisible.
- Latency: a clean pin change first sampled at edge E produces a btn_level change at edge E+SYNC_STAGES+DEBOUNCE_CYCLES-1.
- press_pulse and release_pulse are registered and asserted for exactly the one cycle following the edge that flips btn_level, rising or falling respectively. They are never asserted together.
- Auto-repeat FSM (repeat counter wide enough for max(REPEAT_DELAY, REPEAT_RATE)):
  - IDLE: on press flip, go to DELAY with counter = 0.
  - DELAY: counter increments each clock. At REPEAT_DELAY-1, pulse repeat_pulse, go to REPEAT, counter = 0.
  - REPEAT: counter increments. At REPEAT_RATE-1, pulse repeat_pulse, counter = 0.
  - Release flip in any state: go to IDLE immediately, counter = 0. No repeat_pulse in the release cycle.
  - REPEAT_DELAY = 0: FSM stays in IDLE; repeat_pulse is constant 0.
- Timing: first repeat_pulse occurs REPEAT_DELAY cycles after press_pulse; later pulses every REPEAT_RATE cycles. Counters saturate nowhere; they wrap only via the explicit clears above.
- step_pulse is combinational OR of the two registered strobes, so it adds no extra latency.
- Reset mid-hold: state returns to released. If the pin is still pressed after RST deasserts, a fresh press_pulse follows after full latency. This is intentional.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, ACTIVE_LOW=1, REPEAT_DELAY=20, REPEAT_RATE=8):
- Reset with btn_in=1 held 5 cycles -> all outputs 0 during and after reset; no pulse for 50 cycles.
- Clean press: btn_in 1->0 sampled at edge E, held -> btn_level=1 from edge E+5; press_pulse and step_pulse high for exactly one cycle; release_pulse never high.
- Bounce: btn_in toggles every 2 clocks for 12 clocks, then stays 0 -> zero pulses during bounce; exactly one press_pulse 5 edges after the last toggle.
- Glitch: btn_in low for 3 clocks only -> btn_level stays 0; no pulses.
- Hold 60 cycles after press_pulse at cycle P -> repeat_pulse at P+20, P+28, P+36, P+44, P+52; step_pulse count = 6. Release -> one release_pulse; no further repeats.
- RST asserted mid-REPEAT with pin held low -> outputs 0 immediately; after deassert, new press_pulse 5 edges later and repeat sequence restarts from REPEAT_DELAY.
